// File: rtl/snake_pkg.sv
// Shared collision codes and limits for the snake game datapath.
package snake_pkg;

    localparam logic [1:0] COLL_NONE  = 2'b00;
    localparam logic [1:0] COLL_APPLE = 2'b01;
    localparam logic [1:0] COLL_WALL  = 2'b10;

    localparam int MAX_SNAKES = 8;

    // Isolates the lowest set bit so that only one snake can win the apple.
    function automatic logic [MAX_SNAKES-1:0] lowest_set(input logic [MAX_SNAKES-1:0] v);
        return v & (~v + MAX_SNAKES'(1));
    endfunction

endpackage

// File: rtl/snake_collision_lane.sv
// Per-snake frame accumulator for the wall and apple hit flags.
module snake_collision_lane (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic pix_valid,
    input  logic frame_end,
    input  logic wall_term,
    input  logic apple_term,
    output logic wall_now,
    output logic apple_now
);

    logic wall_acc;
    logic apple_acc;

    // The pixel on the frame_end cycle still belongs to the frame being closed.
    assign wall_now  = wall_acc  | (pix_valid & wall_term);
    assign apple_now = apple_acc | (pix_valid & apple_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wall_acc  <= 1'b0;
            apple_acc <= 1'b0;
        end else if (clr || frame_end) begin
            wall_acc  <= 1'b0;
            apple_acc <= 1'b0;
        end else begin
            wall_acc  <= wall_now;
            apple_acc <= apple_now;
        end
    end

endmodule

// File: rtl/snake_collision_arbiter.sv
// Frame collision resolver and event register for NUM_SNAKES snakes.
// Define SNAKE_HEAD2HEAD_EN to treat head-on-head overlap as a wall hit.
module snake_collision_arbiter
    import snake_pkg::*;
#(
    parameter int NUM_SNAKES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    pix_valid,
    input  logic                    frame_end,
    input  logic                    border,
    input  logic                    apple,
    input  logic                    apple_en,
    input  logic [NUM_SNAKES-1:0]   head,
    input  logic [NUM_SNAKES-1:0]   body,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [2*NUM_SNAKES-1:0] evt_code,
    output logic                    overrun
);

    logic [NUM_SNAKES-1:0]   wall_now;
    logic [NUM_SNAKES-1:0]   apple_now;
    logic [NUM_SNAKES-1:0]   apple_win;
    logic [MAX_SNAKES-1:0]   apple_win_ext;
    logic [2*NUM_SNAKES-1:0] res_code_p0;
    logic                    res_any_p0;

    for (genvar i = 0; i < NUM_SNAKES; i++) begin : g_lane
        logic head_clash;
        logic wall_term;
        logic apple_term;

`ifdef SNAKE_HEAD2HEAD_EN
        assign head_clash = head[i] & |(head & ~(NUM_SNAKES'(1) << i));
`else
        assign head_clash = 1'b0;
`endif
        // Any snake's body counts, including the snake's own.
        assign wall_term  = (head[i] & (border | (|body))) | head_clash;
        assign apple_term = head[i] & apple & apple_en;

        snake_collision_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .pix_valid  (pix_valid),
            .frame_end  (frame_end),
            .wall_term  (wall_term),
            .apple_term (apple_term),
            .wall_now   (wall_now[i]),
            .apple_now  (apple_now[i])
        );
    end

    // A snake that hit a wall is out of the apple race.
    assign apple_win_ext = lowest_set(MAX_SNAKES'(apple_now & ~wall_now));
    assign apple_win     = apple_win_ext[NUM_SNAKES-1:0];

    always_comb begin
        res_code_p0 = '0;
        for (int i = 0; i < NUM_SNAKES; i++) begin
            if (wall_now[i])
                res_code_p0[2*i +: 2] = COLL_WALL;
            else if (apple_win[i])
                res_code_p0[2*i +: 2] = COLL_APPLE;
            else
                res_code_p0[2*i +: 2] = COLL_NONE;
        end
    end

    assign res_any_p0 = |res_code_p0;

    // ---- stage p1: event register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            overrun   <= 1'b0;
        end else if (clr) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            overrun   <= 1'b0;
        end else if (frame_end && res_any_p0) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_code  <= res_code_p0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snake_collision_arbiter.sv
// Randomized and directed bench for snake_collision_arbiter against a frame-level model.
module tb_snake_collision_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst, clr, pix_valid, frame_end, border, apple, apple_en, evt_ready;
    logic [N-1:0]   head, body;
    logic           evt_valid, overrun;
    logic [2*N-1:0] evt_code;

    int n_chk  = 0;
    int n_fail = 0;

    bit             mw[N];
    bit             ma[N];
    bit             m_valid;
    bit             m_ov;
    logic [2*N-1:0] m_code;

    always #5 clk = ~clk;

    snake_collision_arbiter #(.NUM_SNAKES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .pix_valid (pix_valid),
        .frame_end (frame_end),
        .border    (border),
        .apple     (apple),
        .apple_en  (apple_en),
        .head      (head),
        .body      (body),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mw[i] = 1'b0;
            ma[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_code  = '0;
    endtask

    // Frame result from the game rules: walls first, then the first apple-eater.
    function automatic logic [2*N-1:0] resolve();
        logic [2*N-1:0] code;
        bit taken;
        code  = '0;
        taken = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mw[i]) code[2*i +: 2] = 2'b10;
            else if (ma[i] && !taken) begin
                code[2*i +: 2] = 2'b01;
                taken = 1'b1;
            end
        end
        return code;
    endfunction

    task automatic step(input bit pv, input bit fe, input bit bd, input bit ap, input bit ae,
                        input logic [N-1:0] hd, input logic [N-1:0] by, input bit rdy, input bit cl);
        logic [2*N-1:0] code;
        bit consume;
        int heads;
        pix_valid = pv; frame_end = fe; border = bd; apple = ap; apple_en = ae;
        head = hd; body = by; evt_ready = rdy; clr = cl;
        if (cl) begin
            model_clear();
        end else begin
            consume = m_valid && rdy;
            heads = 0;
            for (int i = 0; i < N; i++) heads += int'(hd[i]);
            if (pv) begin
                for (int i = 0; i < N; i++) begin
                    if (hd[i] && (bd || by != 0)) mw[i] = 1'b1;
`ifdef SNAKE_HEAD2HEAD_EN
                    if (hd[i] && heads > 1) mw[i] = 1'b1;
`endif
                    if (hd[i] && ap && ae) ma[i] = 1'b1;
                end
            end
            if (fe) begin
                code = resolve();
                for (int i = 0; i < N; i++) begin
                    mw[i] = 1'b0;
                    ma[i] = 1'b0;
                end
                if (code != 0) begin
                    if (!m_valid || consume) begin
                        m_valid = 1'b1;
                        m_code  = code;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else if (consume) begin
                    m_valid = 1'b0;
                end
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) chk("evt_code", 32'(evt_code), 32'(m_code));
        chk("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, '0, '0, rdy, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; pix_valid = 1'b0; frame_end = 1'b0; border = 1'b0;
        apple = 1'b0; apple_en = 1'b0; head = '0; body = '0; evt_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;

        // Mid-frame asynchronous reset with an event held and overrun set.
        step(1, 1, 1, 0, 0, 2'b01, '0, 0, 0);
        step(1, 1, 1, 0, 0, 2'b10, '0, 0, 0);
        chk("pre_rst_overrun", 32'(overrun), 1);
        step(1, 0, 1, 1, 1, 2'b11, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_code", 32'(evt_code), 0);
        chk("arst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        model_clear();
        step(1, 1, 0, 0, 0, '0, '0, 0, 0);
        chk("post_rst_no_evt", 32'(evt_valid), 0);

        // Wall hit on snake 1, code held until ready.
        step(1, 0, 1, 0, 0, 2'b10, '0, 0, 0);
        step(1, 1, 0, 0, 0, '0, '0, 0, 0);
        chk("wall_valid", 32'(evt_valid), 1);
        chk("wall_code", 32'(evt_code), 32'h8);
        idle(3, 0);
        chk("wall_hold", 32'(evt_code), 32'h8);
        step(1, 0, 0, 0, 0, '0, '0, 1, 0);
        chk("wall_consumed", 32'(evt_valid), 0);

        // Apple tie on the frame_end pixel itself; then apple disabled.
        step(1, 1, 0, 1, 1, 2'b11, '0, 0, 0);
        chk("apple_tie", 32'(evt_code), 32'h1);
        step(1, 0, 0, 0, 0, '0, '0, 1, 0);
        step(1, 1, 0, 1, 0, 2'b11, '0, 0, 0);
        chk("apple_dis", 32'(evt_valid), 0);

        // Snake 0 eats apple and its own body; snake 1 wins the apple.
        step(1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0);
        step(1, 0, 0, 1, 1, 2'b01, '0, 0, 0);
        step(1, 0, 0, 1, 1, 2'b10, '0, 0, 0);
        step(1, 1, 0, 0, 0, '0, '0, 0, 0);
        chk("wall_beats_apple", 32'(evt_code), 32'h6);

        // New hit frame while pending and not ready: dropped with overrun.
        step(1, 0, 1, 0, 0, 2'b01, '0, 0, 0);
        step(1, 1, 0, 0, 0, '0, '0, 0, 0);
        chk("ovr_code", 32'(evt_code), 32'h6);
        chk("ovr_flag", 32'(overrun), 1);

        // clr wins over frame_end and handshake.
        step(1, 1, 1, 0, 0, 2'b10, '0, 1, 1);
        chk("clr_valid", 32'(evt_valid), 0);
        chk("clr_overrun", 32'(overrun), 0);

        // Handshake coincident with frame_end: back-to-back events.
        step(1, 1, 1, 0, 0, 2'b01, '0, 0, 0);
        step(1, 1, 1, 0, 0, 2'b10, '0, 1, 0);
        chk("b2b_valid", 32'(evt_valid), 1);
        chk("b2b_code", 32'(evt_code), 32'h8);
        chk("b2b_overrun", 32'(overrun), 0);
        step(1, 0, 0, 0, 0, '0, '0, 1, 0);

        // Head-on-head overlap.
        step(1, 1, 0, 0, 0, 2'b11, '0, 0, 0);
`ifdef SNAKE_HEAD2HEAD_EN
        chk("h2h_code", 32'(evt_code), 32'hA);
`else
        chk("h2h_none", 32'(evt_valid), 0);
`endif
        step(1, 0, 0, 0, 0, '0, '0, 1, 0);

        // Randomized frames.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] hd, by;
            hd = ($urandom % 3 == 0) ? N'($urandom) : '0;
            by = ($urandom % 5 == 0) ? N'($urandom) : '0;
            step($urandom % 4 != 0, $urandom % 30 == 0, $urandom % 12 == 0,
                 $urandom % 6 == 0, $urandom % 4 != 0, hd, by,
                 $urandom % 3 == 0, $urandom % 600 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_collision_arbiter.md
# snake_collision_arbiter

Multi-snake collision detector and event arbiter for the VGA snake game. It sits between the pixel renderer and the game-control FSM. Per-pixel head/body/border/apple hits for `NUM_SNAKES` snakes accumulate over one video frame. At frame end they resolve into one per-snake collision code, with single-winner apple arbitration, and the result is delivered to the game FSM through a valid/ready handshake.

## Interface
- `NUM_SNAKES`, default 2: number of snakes, 1–8.
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear (new game); same effect as reset, one cycle.
- `pix_valid`  in  1  current pixel is in the active video region.
- `frame_end`  in  1  one-cycle pulse on the last active pixel of a frame.
- `border`  in  1  current pixel is a wall.
- `apple`  in  1  current pixel is the apple.
- `apple_en`  in  1  apple is live; apple hits are ignored while low.
- `head`  in  `NUM_SNAKES`  bit i: pixel is snake i's head.
- `body`  in  `NUM_SNAKES`  bit i: pixel is snake i's body.
- `evt_valid`  out  1  resolved frame event available.
- `evt_ready`  in  1  game FSM accepts the event.
- `evt_code`  out  `2*NUM_SNAKES`  per-snake code in bits [2i+1:2i]: `2'b10` wall, `2'b01` apple, `2'b00` none.
- `overrun`  out  1  sticky flag: an event was dropped.

## Operation
- Per lane i, evaluated only when `pix_valid` is high:
  - wall_hit[i] is set on `head[i] && (border || |body)`. Any snake's body counts, including its own.
  - apple_hit[i] is set on `head[i] && apple && apple_en`.
- Hit flags are sticky until the frame closes.
- Resolution on `frame_end`:
  - The pixel on the `frame_end` cycle is included in the frame being closed.
  - wall[i] = wall_hit[i].
  - The apple winner is the lowest index i with apple_hit[i] and not wall[i]. At most one snake gets code `01` per event.
  - A snake with wall and apple hits reports `10`.
  - After resolution, all lane accumulators are cleared.
- Event register:
  - An event is loaded only if some code is nonzero. A frame with no hits produces nothing.
  - On load, `evt_valid` rises. `evt_code` is held stable while `evt_valid && !evt_ready`.
  - The event is consumed on `evt_valid && evt_ready`.
  - `frame_end` with a nonzero result while an event is pending and not being consumed: the new event is dropped, the held event is unchanged, and `overrun` is set.
  - `frame_end` on the same cycle as a handshake: the old event is consumed and the new one loaded, with `evt_valid` staying high. No overrun.
- Reset and `clr`:
  - `evt_valid`=0, `evt_code`=0, `overrun`=0, accumulators cleared.
  - `clr` overrides `frame_end` and the handshake in the same cycle.
  - Reset asserted mid-frame discards the partial frame.

## Timing
- Accumulators update on the clock edge after a qualifying pixel.
- `evt_valid`/`evt_code` are registered and valid on the cycle after `frame_end`: latency 1.
- There is no combinational path from `evt_ready` to any output.
- The FSM must keep `evt_ready` high for at least one cycle; the minimum handshake is 1 cycle.
- `overrun` clears only on `rst` or `clr`.

## Configuration
- `SNAKE_HEAD2HEAD_EN` defined:
  - `head[i] && head[j]` (j≠i) on the same valid pixel also sets wall_hit for both i and j.
  - With `NUM_SNAKES`=1 this has no effect.
- Undefined:
  - Head-on-head overlap is not a collision. Only head-on-body, border and apple hits are detected.

## Structure
- Shared package `snake_pkg`:
  - `localparam` codes `COLL_NONE`=2'b00, `COLL_APPLE`=2'b01, `COLL_WALL`=2'b10.
  - `MAX_SNAKES`=8.
- Sub-module `snake_collision_lane`:
  - Instantiated once per snake (generate loop).
  - Holds the wall_hit/apple_hit accumulators, with inputs pix_valid, frame_end, clr and per-lane hit terms.
- The top level holds the head-to-head term, the lowest-index apple priority picker, the event register and overrun.

## Test plan
- Reset: assert `rst` mid-frame with hits accumulated, then release. Required: no event on the next `frame_end`, and `evt_valid`=0, `evt_code`=0, `overrun`=0.
- Snake wall hit: `NUM_SNAKES`=2; `head`=2'b10 with `border`=1 on one pixel, then `frame_end`. Required: one cycle later `evt_valid`=1 and `evt_code`=4'b1000. The code holds until `evt_ready`, and `evt_valid` drops the next cycle.
- Apple tie: `head`=2'b11, `apple`=1, `apple_en`=1 on the same pixel, then `frame_end`. Required: `evt_code`=4'b0001. Repeat with `apple_en`=0: no event.
- Wall beats apple: snake 0 hits apple and own body in the same frame, and snake 1 hits the apple. Required: `evt_code`=4'b0110.
- Overrun and handshake: event pending with `evt_ready`=0 when a new hit frame ends. Required: code unchanged and `overrun`=1. Then repeat with `evt_ready`=1 on the `frame_end` cycle: new code loaded, `evt_valid` continuous, no overrun.
- Head-to-head: `head`=2'b11 with `border`=0 and `body`=0, then `frame_end`. Required: `4'b1010` with `SNAKE_HEAD2HEAD_EN` defined, and no event without it.
